alu_seq_controller: RTL

Parametrised, registered successor to the multicycle datapath's ALU control decode. Decodes `aluop`/`funct` into the 4-bit ALU opcode, latches operands and executes the operation. Single-cycle ops complete in one cycle. Iterative shift and multiply ops take several cycles. A start/busy/done handshake lets the control FSM stall on long operations.

---
 rtl/alu_seq_controller.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_controller.sv
// alu_seq_controller: registered ALU decode and execute unit.
// Single-cycle ops finish in one cycle, while shifts and multiply iterate bit by bit.
module alu_seq_controller #(
   parameter int DATA_W  = 16,
   parameter int SHAMT_W = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        aluop,
   input  logic [1:0]        funct,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [3:0]        op,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b0001;
   localparam logic [3:0] OP_OR  = 4'b0010;
   localparam logic [3:0] OP_SLT = 4'b1111;
   localparam logic [3:0] OP_SLL = 4'b0101;
   localparam logic [3:0] OP_SRL = 4'b0110;
   localparam logic [3:0] OP_MUL = 4'b0111;
   localparam logic [3:0] OP_ILL = 4'b1000;

   typedef enum logic {IDLE, EXEC} state_t;

   state_t              state_q, state_d;
   logic [3:0]          op_q, op_d;
   logic [DATA_W-1:0]   x_q, x_d;
   logic [DATA_W-1:0]   y_q, y_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                zero_q, zero_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic [3:0]          dec_op;
   logic [DATA_W-1:0]   alu_res;
   logic [DATA_W-1:0]   step_res;
   logic [SHAMT_W-1:0]  amt;

   assign amt = b[SHAMT_W-1:0];

   // Map the control FSM's aluop/funct pair onto the ALU opcode.
   always_comb begin
      dec_op = OP_ILL;
      case (aluop)
         3'b000: dec_op = funct[0] ? OP_SUB : OP_ADD;
         3'b001: begin
            case (funct)
               2'b00:   dec_op = OP_AND;
               2'b01:   dec_op = OP_OR;
               default: dec_op = OP_SLT;
            endcase
         end
         3'b010: dec_op = OP_ADD;
         3'b011: dec_op = OP_SUB;
         3'b100: dec_op = OP_OR;
         3'b101: dec_op = OP_AND;
         3'b110: dec_op = OP_SLT;
         default: begin
            case (funct)
               2'b00:   dec_op = OP_SLL;
               2'b01:   dec_op = OP_SRL;
               2'b10:   dec_op = OP_MUL;
               default: dec_op = OP_ILL;
            endcase
         end
      endcase
   end

   // One-cycle result; a zero-amount shift simply passes a through.
   always_comb begin
      alu_res = '0;
      case (dec_op)
         OP_ADD: alu_res = a + b;
         OP_SUB: alu_res = a - b;
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_SLT: alu_res = {{(DATA_W-1){1'b0}},
                            ($signed(a) < $signed(b))};
         OP_SLL: alu_res = a;
         OP_SRL: alu_res = a;
         default: alu_res = '0;
      endcase
   end

   // Next state: accept in IDLE, iterate one bit per edge in EXEC.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      x_d      = x_q;
      y_d      = y_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      step_res = x_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d  = dec_op;
               x_d   = a;
               y_d   = b;
               acc_d = '0;
               if ((dec_op == OP_SLL || dec_op == OP_SRL) && amt != '0) begin
                  state_d = EXEC;
                  cnt_d   = CNT_W'(amt);
               end else if (dec_op == OP_MUL) begin
                  state_d = EXEC;
                  cnt_d   = CNT_W'(DATA_W);
               end else begin
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  done_d   = 1'b1;
                  err_d    = (dec_op == OP_ILL);
               end
            end
         end
         default: begin
            if (op_q == OP_MUL) begin
               step_res = y_q[0] ? acc_q + x_q : acc_q;
               acc_d    = step_res;
               x_d      = x_q << 1;
               y_d      = y_q >> 1;
            end else begin
               step_res = (op_q == OP_SLL) ? x_q << 1 : x_q >> 1;
               x_d      = step_res;
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d  = IDLE;
               result_d = step_res;
               zero_d   = (step_res == '0);
               done_d   = 1'b1;
            end
         end
      endcase
   end

   // State and registered outputs; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= 4'b0000;
         x_q      <= '0;
         y_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         x_q      <= x_d;
         y_q      <= y_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign op     = op_q;
   assign result = result_q;
   assign zero   = zero_q;
   assign busy   = (state_q == EXEC);
   assign done   = done_q;
   assign err    = err_q;

endmodule
